serial_alu: RTL and testbench



---
 rtl/serial_alu_pkg.sv | 27 ++
 rtl/serial_alu_if.sv | 24 ++
 rtl/serial_alu_slice.sv | 39 +++
 rtl/serial_alu.sv | 101 ++++++++++
 tb/tb_serial_alu.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU: operation codes, controller states and
// the carry-in rule used when a command is accepted.
package serial_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_INC  = 3'b001,
        OP_SUB  = 3'b010,
        OP_DEC  = 3'b011,
        OP_XOR  = 3'b100,
        OP_AND  = 3'b101,
        OP_OR   = 3'b110,
        OP_ZERO = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // Increment and subtract seed the serial carry with 1 (A+0+1, A+~B+1).
    function automatic logic op_carry_seed(input op_e op);
        return (op == OP_INC) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Command/result handshake bundle between a requester and the serial ALU.
interface serial_alu_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_c;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y, out_c
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y, out_c
    );
endinterface

// File: rtl/serial_alu_slice.sv
// One-bit ALU slice: selects the effective B bit for the op and produces the
// result bit and carry-out. Logic ops ignore carry-in and report carry 0.
module alu_serial_slice
    import serial_alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  op_e  op,
    output logic y,
    output logic cout
);

    logic w_bop;

    always_comb begin
        w_bop = 1'b0;
        y     = 1'b0;
        cout  = 1'b0;
        unique case (op)
            OP_ADD, OP_INC, OP_SUB, OP_DEC: begin
                // Every arithmetic op reduces to A + w_bop + carry.
                unique case (op)
                    OP_ADD:  w_bop = b;
                    OP_SUB:  w_bop = ~b;
                    OP_DEC:  w_bop = 1'b1;
                    default: w_bop = 1'b0;
                endcase
                y    = a ^ w_bop ^ cin;
                cout = (a & w_bop) | (a & cin) | (w_bop & cin);
            end
            OP_XOR:  y = a ^ b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: captures a command, produces one result bit per cycle LSB
// first through a single slice, then holds the result until it is consumed.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_alu_if.slave    bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_next;
    op_e              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_y;
    logic             r_c;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_y;
    logic             w_cout;

    alu_serial_slice u_slice (
        .a    (r_a[r_cnt]),
        .b    (r_b[r_cnt]),
        .cin  (r_carry),
        .op   (r_op),
        .y    (w_y),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (r_cnt == LAST_BIT) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand registers need no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_y     <= '0;
            r_c     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_op    <= op_e'(bus.in_op);
                        r_a     <= bus.in_a;
                        r_b     <= bus.in_b;
                        r_cnt   <= '0;
                        r_carry <= op_carry_seed(op_e'(bus.in_op));
                    end
                end
                ST_RUN: begin
                    r_y[r_cnt] <= w_y;
                    r_c        <= w_cout;
                    r_carry    <= w_cout;
                    r_cnt      <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_y     = r_y;
    assign bus.out_c     = r_c;

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu (WIDTH=4): vector table plus backpressure and
// reset-abort sequences.
module tb_serial_alu;
    import serial_alu_pkg::*;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_alu_if #(.WIDTH(WIDTH)) bus();

    serial_alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        logic       c;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one command, scramble the inputs after acceptance, wait for the
    // result, then consume it.
    task automatic do_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          output logic [3:0] y, output logic c, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_op    = ~op;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        y = bus.out_y;
        c = bus.out_c;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] y;
        logic       c;
        int         lat;
        int         guard;

        vecs[0]  = '{3'b000, 4'b0111, 4'b1011, 4'b0010, 1'b1};
        vecs[1]  = '{3'b010, 4'b0011, 4'b0101, 4'b1110, 1'b0};
        vecs[2]  = '{3'b010, 4'b0101, 4'b0011, 4'b0010, 1'b1};
        vecs[3]  = '{3'b011, 4'b0000, 4'b0110, 4'b1111, 1'b0};
        vecs[4]  = '{3'b001, 4'b1111, 4'b0000, 4'b0000, 1'b1};
        vecs[5]  = '{3'b101, 4'b1100, 4'b1010, 4'b1000, 1'b0};
        vecs[6]  = '{3'b111, 4'b1111, 4'b1111, 4'b0000, 1'b0};
        vecs[7]  = '{3'b000, 4'b0011, 4'b0100, 4'b0111, 1'b0};
        vecs[8]  = '{3'b100, 4'b1100, 4'b1010, 4'b0110, 1'b0};
        vecs[9]  = '{3'b110, 4'b1100, 4'b1010, 4'b1110, 1'b0};
        vecs[10] = '{3'b001, 4'b0101, 4'b1001, 4'b0110, 1'b0};
        vecs[11] = '{3'b011, 4'b1000, 4'b0000, 4'b0111, 1'b1};
        vecs[12] = '{3'b010, 4'b0110, 4'b0110, 4'b0000, 1'b1};
        vecs[13] = '{3'b000, 4'b1111, 4'b1111, 4'b1110, 1'b1};
        vecs[14] = '{3'b010, 4'b0000, 4'b0001, 4'b1111, 1'b0};
        vecs[15] = '{3'b100, 4'b1111, 4'b0000, 4'b1111, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_a      = 4'h0;
        bus.in_b      = 4'h0;
        bus.out_ready = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready",  32'(bus.in_ready),  32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_y",     32'(bus.out_y),     32'd0);
        check("reset out_c",     32'(bus.out_c),     32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_cmd(vecs[i].op, vecs[i].a, vecs[i].b, y, c, lat);
            check($sformatf("vec%0d out_y", i),   32'(y),   32'(vecs[i].y));
            check($sformatf("vec%0d out_c", i),   32'(c),   32'(vecs[i].c));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(WIDTH));
        end

        // Backpressure: result held for 5 cycles while a new command is offered.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'b000;
        bus.in_a     = 4'b0111;
        bus.in_b     = 4'b1011;
        @(negedge clk);
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("bp latency", 32'(guard), 32'(WIDTH));
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = 3'b110;
            bus.in_a     = 4'b0001;
            bus.in_b     = 4'b0001;
            check($sformatf("bp%0d out_valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp%0d in_ready", k),  32'(bus.in_ready),  32'd0);
            check($sformatf("bp%0d out_y", k),     32'(bus.out_y),     32'h2);
            check($sformatf("bp%0d out_c", k),     32'(bus.out_c),     32'd1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp consumed out_valid", 32'(bus.out_valid), 32'd0);
        check("bp idle in_ready",      32'(bus.in_ready),  32'd1);
        check("bp hold out_y",         32'(bus.out_y),     32'h2);
        bus.in_valid = 1'b0;

        // Reset asserted during the second RUN cycle aborts the command.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'b010;
        bus.in_a     = 4'b0101;
        bus.in_b     = 4'b0011;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst run in_ready",  32'(bus.in_ready),  32'd1);
        check("rst run out_valid", 32'(bus.out_valid), 32'd0);
        check("rst run out_y",     32'(bus.out_y),     32'd0);
        check("rst run out_c",     32'(bus.out_c),     32'd0);
        for (int k = 0; k < WIDTH + 2; k++) begin
            @(negedge clk);
            check($sformatf("rst run quiet%0d", k), 32'(bus.out_valid), 32'd0);
        end
        do_cmd(3'b010, 4'b0101, 4'b0011, y, c, lat);
        check("post rst out_y",   32'(y),   32'h2);
        check("post rst out_c",   32'(c),   32'd1);
        check("post rst latency", 32'(lat), 32'(WIDTH));

        // Reset while a result is waiting in DONE discards it.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'b001;
        bus.in_a     = 4'b1111;
        bus.in_b     = 4'b0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("done pre-rst out_c", 32'(bus.out_c), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst done out_valid", 32'(bus.out_valid), 32'd0);
        check("rst done out_c",     32'(bus.out_c),     32'd0);
        check("rst done in_ready",  32'(bus.in_ready),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
